// File: rtl/processor_pkg.sv
// processor_pkg: shared register-file constants, writeback entry type and register names
package processor_pkg;
  localparam int DATA_W = 24;
  localparam int REG_COUNT = 16;
  localparam int REG_ADDR_W = 4;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
  typedef enum logic [REG_ADDR_W-1:0] {
    ZERO = 4'd0,
    SP = 4'd1,
    LR = 4'd2,
    CPSR = 4'd3,
    PC = 4'd15
  } reg_name_t;
  function automatic logic is_real(input logic [REG_ADDR_W-1:0] d);
    return d != ZERO;
  endfunction
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: result inputs, issue announcements and register-file write port
//   master drives alu_*/mem_*/issue_*; slave drives in_ready, issue_ready, reg_write_*, pending_mask, overflow
interface writeback_unit_if #(
  parameter int N = processor_pkg::DATA_W
);
  import processor_pkg::*;
  logic alu_valid;
  logic [REG_ADDR_W-1:0] alu_dest;
  logic [N-1:0] alu_data;
  logic mem_valid;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic [N-1:0] mem_data;
  logic in_ready;
  logic issue_valid;
  logic [REG_ADDR_W-1:0] issue_dest;
  logic issue_ready;
  logic reg_write_en;
  logic [REG_ADDR_W-1:0] reg_write_dest;
  logic [N-1:0] reg_write_data;
  logic [REG_COUNT-1:0] pending_mask;
  logic overflow;
  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, issue_valid, issue_dest,
    input in_ready, issue_ready, reg_write_en, reg_write_dest, reg_write_data, pending_mask, overflow
  );
  modport slave (
    input alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, issue_valid, issue_dest,
    output in_ready, issue_ready, reg_write_en, reg_write_dest, reg_write_data, pending_mask, overflow
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: pending-write queue with two ordered pushes (a before b) and one pop per cycle
//   clk, rst (async high); push_a/data_a, push_b/data_b; pop; head = oldest entry; count = occupancy
module wb_fifo #(
  parameter int W = 28,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic push_a,
  input logic [W-1:0] data_a,
  input logic push_b,
  input logic [W-1:0] data_b,
  input logic pop,
  output logic [W-1:0] head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  assign head = mem[rd];
  // b lands behind a when both push, otherwise takes a's slot
  always_ff @(posedge clk) begin
    if (push_a) mem[wr] <= data_a;
    if (push_b) mem[wr + AW'(push_a)] <= data_b;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(push_a) + AW'(push_b);
      rd <= rd + AW'(pop);
      count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: queues ALU/load results, retires one per cycle to the register file, tracks pending writes
//   clk, rst (async high); bus: slave side of writeback_unit_if
module writeback_unit
  import processor_pkg::*;
#(
  parameter int N = DATA_W,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  writeback_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] count;
  logic [REG_ADDR_W+N-1:0] head;
  logic mem_ok, alu_ok, pop, drop, sat;
  logic [2:0] pend [REG_COUNT];
  logic [REG_COUNT-1:1] inc, dec, under;
  assign mem_ok = bus.mem_valid && is_real(bus.mem_dest);
  assign alu_ok = bus.alu_valid && is_real(bus.alu_dest);
  // two free slots guarantee a dual push never overruns, regardless of pop
  assign bus.in_ready = count <= CW'(DEPTH - 2);
  assign pop = count != '0;
  assign bus.issue_ready = !is_real(bus.issue_dest) || pend[bus.issue_dest] != 3'd7;
  assign drop = !bus.in_ready && (mem_ok || alu_ok);
  assign sat = bus.issue_valid && !bus.issue_ready;
  wb_fifo #(.W(REG_ADDR_W + N), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_a(bus.in_ready && mem_ok),
    .data_a({bus.mem_dest, bus.mem_data}),
    .push_b(bus.in_ready && alu_ok),
    .data_b({bus.alu_dest, bus.alu_data}),
    .pop(pop),
    .head(head),
    .count(count)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_write_en <= 1'b0;
      bus.reg_write_dest <= '0;
      bus.reg_write_data <= '0;
    end else begin
      bus.reg_write_en <= pop;
      if (pop) {bus.reg_write_dest, bus.reg_write_data} <= head;
    end
  end
  always_comb begin
    inc = '0;
    dec = '0;
    under = '0;
    bus.pending_mask = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      inc[r] = bus.issue_valid && bus.issue_ready && bus.issue_dest == REG_ADDR_W'(r);
      dec[r] = bus.reg_write_en && bus.reg_write_dest == REG_ADDR_W'(r);
      under[r] = dec[r] && !inc[r] && pend[r] == '0;
      bus.pending_mask[r] = pend[r] != '0;
    end
  end
  // pend[0] is held at zero so register 0 never looks busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int r = 0; r < REG_COUNT; r++) pend[r] <= '0;
    else for (int r = 1; r < REG_COUNT; r++)
      pend[r] <= inc[r] && !dec[r] ? pend[r] + 3'd1 :
                 dec[r] && !inc[r] && pend[r] != '0 ? pend[r] - 3'd1 : pend[r];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.overflow <= 1'b0;
    else if (drop || sat || (|under)) bus.overflow <= 1'b1;
  end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: scoreboard bench for writeback_unit
module tb_writeback_unit;
  localparam int N = 24;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  writeback_unit_if #(.N(N)) bus();
  writeback_unit #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [N+3:0] sb [$];
  logic m_we;
  logic [3:0] m_wdest;
  logic [N-1:0] m_wdata;
  logic m_ovf;
  logic [2:0] m_pend [16];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      m_we <= 1'b0;
      m_wdest <= '0;
      m_wdata <= '0;
      m_ovf <= 1'b0;
      for (int i = 0; i < 16; i++) m_pend[i] <= '0;
    end else begin : mdl
      int sz;
      logic ovf;
      logic [N+3:0] e;
      sz = sb.size();
      ovf = 1'b0;
      if (sz != 0) begin
        e = sb.pop_front();
        m_we <= 1'b1;
        m_wdest <= e[N+3:N];
        m_wdata <= e[N-1:0];
      end else m_we <= 1'b0;
      if (bus.mem_valid && bus.mem_dest != 0) begin
        if (sz <= DEPTH - 2) sb.push_back({bus.mem_dest, bus.mem_data});
        else ovf = 1'b1;
      end
      if (bus.alu_valid && bus.alu_dest != 0) begin
        if (sz <= DEPTH - 2) sb.push_back({bus.alu_dest, bus.alu_data});
        else ovf = 1'b1;
      end
      if (bus.issue_valid && bus.issue_dest != 0 && m_pend[bus.issue_dest] == 3'd7) ovf = 1'b1;
      for (int i = 1; i < 16; i++) begin
        if (bus.issue_valid && bus.issue_dest == i && m_pend[i] != 3'd7) begin
          if (!(m_we && m_wdest == i)) m_pend[i] <= m_pend[i] + 3'd1;
        end else if (m_we && m_wdest == i) begin
          if (m_pend[i] == 0) ovf = 1'b1;
          else m_pend[i] <= m_pend[i] - 3'd1;
        end
      end
      if (ovf) m_ovf <= 1'b1;
    end
  end
  always @(negedge clk) begin : mon
    logic [15:0] em;
    logic eir;
    em = '0;
    for (int i = 1; i < 16; i++) em[i] = m_pend[i] != 0;
    eir = bus.issue_dest == 0 || m_pend[bus.issue_dest] != 3'd7;
    compared++;
    if (bus.reg_write_en !== m_we) begin
      mismatched++;
      $display("FAIL sb_write_en: got %b expected %b at %0t", bus.reg_write_en, m_we, $time);
    end
    if (m_we) begin
      compared++;
      if ({bus.reg_write_dest, bus.reg_write_data} !== {m_wdest, m_wdata}) begin
        mismatched++;
        $display("FAIL sb_write: got dest %0d data %h expected dest %0d data %h", bus.reg_write_dest, bus.reg_write_data, m_wdest, m_wdata);
      end
    end
    compared++;
    if ({bus.pending_mask, bus.overflow, bus.in_ready, bus.issue_ready} !== {em, m_ovf, sb.size() <= DEPTH - 2, eir}) begin
      mismatched++;
      $display("FAIL sb_status: got mask %h ovf %b in_ready %b issue_ready %b expected %h %b %b %b", bus.pending_mask, bus.overflow, bus.in_ready, bus.issue_ready, em, m_ovf, sb.size() <= DEPTH - 2, eir);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_dest = '0;
    bus.alu_data = '0;
    bus.mem_valid = 1'b0;
    bus.mem_dest = '0;
    bus.mem_data = '0;
    bus.issue_valid = 1'b0;
    bus.issue_dest = '0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_dest = 4'd7;
    rst = 1'b1;
    tick();
    tick();
    compared++;
    if ({bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.pending_mask, bus.overflow, bus.in_ready, bus.issue_ready} !== {1'b0, 4'd0, 24'd0, 16'd0, 1'b0, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_state: got en %b dest %0d data %h mask %h ovf %b in_ready %b issue_ready %b", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.pending_mask, bus.overflow, bus.in_ready, bus.issue_ready);
    end
    idle();
    rst = 1'b0;
  endtask
  task automatic test_single();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_dest = 4'd4;
    bus.alu_data = 24'h00ABCD;
    tick();
    idle();
    compared++;
    if (bus.reg_write_en !== 1'b0) begin
      mismatched++;
      $display("FAIL single_early: got en %b expected 0", bus.reg_write_en);
    end
    tick();
    compared++;
    if ({bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data} !== {1'b1, 4'd4, 24'h00ABCD}) begin
      mismatched++;
      $display("FAIL single_write: got en %b dest %0d data %h expected 1 4 00abcd", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data);
    end
    tick();
    compared++;
    if (bus.reg_write_en !== 1'b0) begin
      mismatched++;
      $display("FAIL single_pulse: got en %b expected 0", bus.reg_write_en);
    end
  endtask
  task automatic test_order();
    do_reset();
    bus.mem_valid = 1'b1;
    bus.mem_dest = 4'd5;
    bus.mem_data = 24'h000111;
    bus.alu_valid = 1'b1;
    bus.alu_dest = 4'd6;
    bus.alu_data = 24'h000222;
    tick();
    idle();
    tick();
    compared++;
    if ({bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data} !== {1'b1, 4'd5, 24'h000111}) begin
      mismatched++;
      $display("FAIL order_first: got en %b dest %0d data %h expected 1 5 000111", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data);
    end
    tick();
    compared++;
    if ({bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data} !== {1'b1, 4'd6, 24'h000222}) begin
      mismatched++;
      $display("FAIL order_second: got en %b dest %0d data %h expected 1 6 000222", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data);
    end
    tick();
    compared++;
    if (bus.reg_write_en !== 1'b0) begin
      mismatched++;
      $display("FAIL order_end: got en %b expected 0", bus.reg_write_en);
    end
  endtask
  task automatic test_dest0();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_dest = 4'd0;
    bus.alu_data = 24'hFFFFFF;
    repeat (3) tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({bus.reg_write_en, bus.in_ready, bus.overflow} !== 3'b010) begin
        mismatched++;
        $display("FAIL dest0: got en %b in_ready %b ovf %b expected 0 1 0", bus.reg_write_en, bus.in_ready, bus.overflow);
      end
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus.mem_valid = 1'b1;
      bus.mem_dest = 4'(2 * c + 1);
      bus.mem_data = 24'(24'h100 + c);
      bus.alu_valid = 1'b1;
      bus.alu_dest = 4'(2 * c + 2);
      bus.alu_data = 24'(24'h200 + c);
      tick();
      if (c == 1) begin
        compared++;
        if ({bus.in_ready, bus.overflow} !== 2'b00) begin
          mismatched++;
          $display("FAIL bp_full: got in_ready %b ovf %b expected 0 0", bus.in_ready, bus.overflow);
        end
      end
      if (c == 2) begin
        compared++;
        if (bus.overflow !== 1'b1) begin
          mismatched++;
          $display("FAIL bp_drop: got ovf %b expected 1", bus.overflow);
        end
      end
    end
    idle();
    repeat (6) tick();
    compared++;
    if ({bus.reg_write_en, bus.in_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL bp_drained: got en %b in_ready %b expected 0 1", bus.reg_write_en, bus.in_ready);
    end
  endtask
  task automatic test_pending();
    do_reset();
    bus.issue_valid = 1'b1;
    bus.issue_dest = 4'd7;
    repeat (3) tick();
    idle();
    compared++;
    if (bus.pending_mask !== 16'h0080) begin
      mismatched++;
      $display("FAIL pend_issued: got mask %h expected 0080", bus.pending_mask);
    end
    for (int c = 0; c < 3; c++) begin
      bus.alu_valid = 1'b1;
      bus.alu_dest = 4'd7;
      bus.alu_data = 24'(24'h700 + c);
      tick();
    end
    idle();
    tick();
    compared++;
    if (bus.pending_mask[7] !== 1'b1) begin
      mismatched++;
      $display("FAIL pend_before_last: got %b expected 1", bus.pending_mask[7]);
    end
    tick();
    compared++;
    if ({bus.pending_mask, bus.overflow} !== {16'h0000, 1'b0}) begin
      mismatched++;
      $display("FAIL pend_cleared: got mask %h ovf %b expected 0000 0", bus.pending_mask, bus.overflow);
    end
    bus.issue_valid = 1'b1;
    bus.issue_dest = 4'd7;
    repeat (7) tick();
    compared++;
    if (bus.issue_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL pend_saturated: got issue_ready %b expected 0", bus.issue_ready);
    end
    tick();
    idle();
    #1;
    compared++;
    if ({bus.overflow, bus.pending_mask, bus.issue_ready} !== {1'b1, 16'h0080, 1'b1}) begin
      mismatched++;
      $display("FAIL pend_over: got ovf %b mask %h issue_ready %b expected 1 0080 1", bus.overflow, bus.pending_mask, bus.issue_ready);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.mem_valid = 1'b1;
    bus.mem_dest = 4'd3;
    bus.mem_data = 24'h00000A;
    bus.alu_valid = 1'b1;
    bus.alu_dest = 4'd8;
    bus.alu_data = 24'h00000B;
    bus.issue_valid = 1'b1;
    bus.issue_dest = 4'd3;
    tick();
    idle();
    bus.alu_valid = 1'b1;
    bus.alu_dest = 4'd9;
    bus.alu_data = 24'h00000C;
    tick();
    idle();
    compared++;
    if ({bus.reg_write_en, bus.pending_mask[3]} !== 2'b11) begin
      mismatched++;
      $display("FAIL mid_busy: got en %b mask3 %b expected 1 1", bus.reg_write_en, bus.pending_mask[3]);
    end
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.pending_mask, bus.overflow, bus.in_ready} !== {1'b0, 4'd0, 24'd0, 16'd0, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL mid_reset: got en %b dest %0d data %h mask %h ovf %b in_ready %b", bus.reg_write_en, bus.reg_write_dest, bus.reg_write_data, bus.pending_mask, bus.overflow, bus.in_ready);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (bus.reg_write_en !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_after: got en %b expected 0 (cycle %0d)", bus.reg_write_en, i);
      end
    end
  endtask
  initial begin
    idle();
    test_reset();
    test_single();
    test_order();
    test_dest0();
    test_backpressure();
    test_pending();
    test_reset_mid();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
